mod_reduce_seq: RTL and testbench



---
 rtl/mod_rsa_pkg.sv | 17 +
 rtl/mod_sub_step.sv | 25 ++
 rtl/mod_reduce_seq.sv | 129 ++++++++++++
 tb/tb_mod_reduce_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_rsa_pkg.sv
// Shared definitions for the RSA modular-reduction datapath: FSM states,
// default operand width and counter sizing.
package mod_rsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int RSA_WIDTH = 256;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, subtract the modulus when it fits, emit the quotient bit.
module mod_sub_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             d_bit,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic           ge;

    // A set top bit of R would place the shifted value beyond any modulus,
    // so it forces the subtract; in normal operation R[WIDTH] stays 0.
    always_comb begin
        t     = {r_in[WIDTH-1:0], d_bit};
        ge    = r_in[WIDTH] | (t >= {1'b0, m});
        r_out = ge ? (t - {1'b0, m}) : t;
        q_bit = ge;
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// Constant-time sequential reducer: remainder and quotient by restoring
// division, one quotient bit per clock, WIDTH cycles per operation.
module mod_reduce_seq
    import mod_rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             dz_r_q, dz_r_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   r_step;
    logic             q_bit;
    logic             accept;
    logic             last_iter;

    mod_sub_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .d_bit (q_q[WIDTH-1]),
        .m     (m_q),
        .r_out (r_step),
        .q_bit (q_bit)
    );

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        m_d         = m_q;
        dz_r_d      = dz_r_q;
        out_valid_d = out_valid_q;
        remainder_d = remainder_q;
        quotient_d  = quotient_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                r_d   = r_step;
                q_d   = {q_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    remainder_d = r_step[WIDTH-1:0];
                    quotient_d  = {q_q[WIDTH-2:0], q_bit};
                    div_zero_d  = dz_r_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Operands are captured only on the accepting edge.
        if (accept) begin
            r_d    = '0;
            q_d    = dividend;
            m_d    = modulus;
            dz_r_d = (modulus == '0);
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            remainder_q <= '0;
            quotient_q  <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            remainder_q <= remainder_d;
            quotient_q  <= quotient_d;
            div_zero_q  <= div_zero_d;
        end
    end

    // Working registers hold data only; their contents are ignored until reloaded.
    always_ff @(posedge clk) begin
        r_q    <= r_d;
        q_q    <= q_d;
        m_q    <= m_d;
        dz_r_q <= dz_r_d;
    end

    assign out_valid = out_valid_q;
    assign remainder = remainder_q;
    assign quotient  = quotient_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Scoreboard bench for mod_reduce_seq at WIDTH=8 and WIDTH=256.
module tb_mod_reduce_seq;

    typedef struct {
        logic [255:0] rem;
        logic [255:0] quo;
        logic         dz;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic         iv8 = 1'b0, or8 = 1'b1;
    logic         ir8, ov8, dz8;
    logic [7:0]   d8 = '0, m8 = '0, r8, qq8;
    logic         ivw = 1'b0, orw = 1'b1;
    logic         irw, ovw, dzw;
    logic [255:0] dw = '0, mw = '0, rw, qqw;

    exp_t q8[$];
    exp_t qw[$];

    mod_reduce_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .dividend(d8), .modulus(m8), .out_valid(ov8), .out_ready(or8),
        .remainder(r8), .quotient(qq8), .div_zero(dz8)
    );

    mod_reduce_seq #(.WIDTH(256)) dutw (
        .clk(clk), .reset(reset), .in_valid(ivw), .in_ready(irw),
        .dividend(dw), .modulus(mw), .out_valid(ovw), .out_ready(orw),
        .remainder(rw), .quotient(qqw), .div_zero(dzw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer division, zero modulus yields dividend / all ones.
    function automatic exp_t model(input logic [255:0] d, input logic [255:0] m, input int w);
        exp_t e;
        logic [255:0] ones;
        ones = (w == 256) ? '1 : ((256'd1 << w) - 256'd1);
        if (m == 0) begin
            e.rem = d; e.quo = ones; e.dz = 1'b1;
        end else begin
            e.rem = d % m; e.quo = d / m; e.dz = 1'b0;
        end
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    // Monitors: pop and compare on every transfer, check hold stability and latency.
    logic       seen8 = 1'b0, seenw = 1'b0;
    int         start8 = 0, startw = 0;
    logic [7:0] p_r8, p_q8;
    logic [255:0] p_rw, p_qw;

    always @(negedge clk) begin
        exp_t e;
        if (reset) seen8 = 1'b0;
        else if (ov8) begin
            if (seen8) begin
                chk("hold_rem8", r8, p_r8);
                chk("hold_quo8", qq8, p_q8);
            end else begin
                seen8 = 1'b1;
                start8 = cyc;
            end
            p_r8 = r8; p_q8 = qq8;
            if (or8) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected8 actual=out_valid required=no_result");
                end else begin
                    e = q8.pop_front();
                    chk("rem8", r8, e.rem);
                    chk("quo8", qq8, e.quo);
                    chk("dz8", dz8, e.dz);
                    chk("lat8", start8 - e.acc, 8);
                end
                seen8 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) seenw = 1'b0;
        else if (ovw) begin
            if (seenw) begin
                chk("hold_remw", rw, p_rw);
                chk("hold_quow", qqw, p_qw);
            end else begin
                seenw = 1'b1;
                startw = cyc;
            end
            p_rw = rw; p_qw = qqw;
            if (orw) begin
                if (qw.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpectedw actual=out_valid required=no_result");
                end else begin
                    e = qw.pop_front();
                    chk("remw", rw, e.rem);
                    chk("quow", qqw, e.quo);
                    chk("dzw", dzw, e.dz);
                    chk("latw", startw - e.acc, 256);
                end
                seenw = 1'b0;
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [7:0] m, input bit hold, output int acc);
        exp_t e;
        int n;
        acc = -1;
        @(posedge clk); #1;
        iv8 = 1'b1; d8 = d; m8 = m;
        n = 0;
        @(negedge clk);
        while (!ir8 && n < 100) begin @(negedge clk); n++; end
        if (!ir8) begin
            total++; bad++;
            $display("FAIL accept8 actual=in_ready_low required=accept");
            iv8 = 1'b0;
            return;
        end
        e = model({248'd0, d}, {248'd0, m}, 8);
        e.acc = cyc + 1;
        acc = e.acc;
        q8.push_back(e);
        @(posedge clk); #1;
        if (!hold) iv8 = 1'b0;
        @(negedge clk);
        chk("in_ready8_run", ir8, 1'b0);
    endtask

    task automatic sendw(input logic [255:0] d, input logic [255:0] m);
        exp_t e;
        int n;
        @(posedge clk); #1;
        ivw = 1'b1; dw = d; mw = m;
        n = 0;
        @(negedge clk);
        while (!irw && n < 600) begin @(negedge clk); n++; end
        if (!irw) begin
            total++; bad++;
            $display("FAIL acceptw actual=in_ready_low required=accept");
            ivw = 1'b0;
            return;
        end
        e = model(d, m, 256);
        e.acc = cyc + 1;
        qw.push_back(e);
        @(posedge clk); #1;
        ivw = 1'b0;
        // Operand changes during RUN must not disturb the result.
        dw = rand256(); mw = rand256();
        @(negedge clk);
        chk("in_ready_w_run", irw, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || qw.size() != 0) && n < 3000) begin
            @(negedge clk); n++;
        end
        if (q8.size() != 0 || qw.size() != 0) begin
            total++; bad++;
            $display("FAIL drain actual=%0d_pending required=0", q8.size() + qw.size());
            q8.delete(); qw.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, n;
        logic [7:0] rd, rm;
        logic [255:0] bd, bm;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ov8", ov8, 1'b0);
        chk("rst_rem8", r8, 8'd0);
        chk("rst_quo8", qq8, 8'd0);
        chk("rst_dz8", dz8, 1'b0);
        chk("rst_ir8", ir8, 1'b1);
        chk("rst_irw", irw, 1'b1);

        send8(8'd200, 8'd7, 1'b0, a1); drain();
        send8(8'd45, 8'd0, 1'b0, a1); drain();

        // Back-to-back: second accept lands on the DONE cycle of the first.
        send8(8'd5, 8'd9, 1'b1, a1);
        send8(8'd255, 8'd1, 1'b0, a2);
        chk("b2b_gap", a2 - a1, 9);
        drain();

        // Backpressure: result held while out_ready is low.
        or8 = 1'b0;
        send8(8'd173, 8'd11, 1'b0, a1);
        n = 0;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid8", ov8, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_ir8", ir8, 1'b0);
            chk("bp_ov8", ov8, 1'b1);
        end
        @(posedge clk); #1 or8 = 1'b1;
        drain();
        chk("bp_drop8", ov8, 1'b0);

        // Reset while an operation is mid-flight.
        send8(8'd99, 8'd4, 1'b0, a1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("mid_rst_ov8", ov8, 1'b0);
        chk("mid_rst_rem8", r8, 8'd0);
        chk("mid_rst_quo8", qq8, 8'd0);
        chk("mid_rst_ir8", ir8, 1'b1);
        repeat (12) begin
            @(negedge clk);
            chk("mid_rst_quiet8", ov8, 1'b0);
        end
        send8(8'd250, 8'd3, 1'b0, a1); drain();

        for (int i = 0; i < 25; i++) begin
            rd = 8'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            send8(rd, rm, 1'b0, a1);
            drain();
        end

        bd = (256'd1 << 255) + 256'd12345;
        bm = (256'd1 << 128) + 256'd1;
        sendw(bd, bm); drain();
        sendw(rand256(), 256'd0); drain();
        for (int i = 0; i < 4; i++) begin
            bd = rand256();
            bm = rand256() >> $urandom_range(0, 250);
            sendw(bd, bm);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
